// File: rtl/fifo_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_arbiter_pkg
//   Shared definitions for the FIFO read-port arbiter slice:
//   - state_t   : arbiter FSM state encoding (IDLE / BURST)
//   - clog2_min1: ceiling log2 that never returns less than 1, used to size
//                 the round-robin index and the burst counter.
// ---------------------------------------------------------------------------
package fifo_rd_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_arbiter_if
//   Bundle of the consumer handshake, FIFO read side and broadcast data.
//   master : the arbiter (consumes req/rdy/rd_empty/rd_data, drives the rest)
//   slave  : the environment (consumers + FIFO read-pointer logic)
//   Signals:
//     req[NUM_REQ]        consumer wants words (level)
//     rdy[NUM_REQ]        consumer can take a word this cycle
//     rd_empty            FIFO empty flag (rd_clk domain)
//     rd_data[DATA_WIDTH] FIFO word at the current read address
//     rd_inc              pop strobe into the FIFO read pointer
//     gnt[NUM_REQ]        registered one-hot grant
//     out_data            broadcast copy of rd_data
//     out_valid[NUM_REQ]  per-consumer word strobe
//     busy                high while a burst is in progress
// ---------------------------------------------------------------------------
interface fifo_rd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    rdy;
    logic                  rd_empty;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_inc;
    logic [NUM_REQ-1:0]    gnt;
    logic [DATA_WIDTH-1:0] out_data;
    logic [NUM_REQ-1:0]    out_valid;
    logic                  busy;

    modport master (
        input  req, rdy, rd_empty, rd_data,
        output rd_inc, gnt, out_data, out_valid, busy
    );

    modport slave (
        output req, rdy, rd_empty, rd_data,
        input  rd_inc, gnt, out_data, out_valid, busy
    );
endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// fifo_rd_arbiter_rr_pick
//   Combinational rotating-priority picker. Scans req starting at
//   rr_last+1 and wrapping modulo NUM_REQ; the first asserted index wins.
//   Ports:
//     req     in  NUM_REQ  request vector
//     rr_last in  IDX_W    index granted most recently
//     pick    out NUM_REQ  one-hot winner (0 when no request)
//     idx     out IDX_W    binary index of the winner
//     any     out 1        at least one request present
// ---------------------------------------------------------------------------
module fifo_rd_arbiter_rr_pick
    import fifo_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_last,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    always_comb begin
        int unsigned            cand;
        logic [NUM_REQ-1:0]     cand_oh;
        pick    = '0;
        idx     = '0;
        any     = 1'b0;
        cand    = 0;
        cand_oh = '0;
        // Offsets 1..NUM_REQ so rr_last itself is checked last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand    = (int'(rr_last) + i) % NUM_REQ;
            cand_oh = ONE << cand;
            if (!any && (|(req & cand_oh))) begin
                any  = 1'b1;
                pick = cand_oh;
                idx  = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rd_arbiter
//   Read-port scheduler for the async FIFO read side (rd_clk domain).
//   Shares the single FIFO read port among NUM_REQ consumers with a
//   round-robin grant of up to BURST_LEN words per grant. Every grant
//   returns through IDLE, so there is one bubble cycle between grants.
//   Ports:
//     rd_clk  in  read-domain clock, rising edge
//     rd_rst  in  asynchronous active-low reset
//     bus     fifo_rd_arbiter_if.master: req/rdy/rd_empty/rd_data in,
//             rd_inc/gnt/out_data/out_valid/busy out
// ---------------------------------------------------------------------------
module fifo_rd_arbiter
    import fifo_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    fifo_rd_arbiter_if.master bus
);

    localparam int IDX_W = clog2_min1(NUM_REQ);
    localparam int CNT_W = clog2_min1(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] RR_INIT  = IDX_W'(NUM_REQ - 1);

    state_t               state_q,   state_nxt;
    logic [NUM_REQ-1:0]   gnt_q,     gnt_nxt;
    logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_nxt;
    logic [CNT_W-1:0]     cnt_q,     cnt_nxt;
    logic [IDX_W-1:0]     rr_last_q, rr_last_nxt;

    logic [NUM_REQ-1:0]   pick;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 xfer;
    logic                 req_held;
    logic [DATA_WIDTH-1:0] data_bcast;

    fifo_rd_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (bus.req),
        .rr_last (rr_last_q),
        .pick    (pick),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    // A word moves only when the granted consumer still wants it, can take
    // it, and the FIFO has one. gnt_q is zero outside BURST, so this is
    // also zero in IDLE and during reset.
    assign xfer     = (|(gnt_q & bus.req & bus.rdy)) & ~bus.rd_empty;
    assign req_held = |(gnt_q & bus.req);

    assign data_bcast    = bus.rd_data;
    assign bus.out_data  = data_bcast;
    assign bus.rd_inc    = xfer;
    assign bus.out_valid = gnt_q & {NUM_REQ{xfer}};
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q == ST_BURST);

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            cnt_q     <= '0;
            rr_last_q <= RR_INIT;
        end else begin
            state_q   <= state_nxt;
            gnt_q     <= gnt_nxt;
            gnt_idx_q <= gnt_idx_nxt;
            cnt_q     <= cnt_nxt;
            rr_last_q <= rr_last_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        gnt_nxt     = gnt_q;
        gnt_idx_nxt = gnt_idx_q;
        cnt_nxt     = cnt_q;
        rr_last_nxt = rr_last_q;

        unique case (state_q)
            ST_IDLE: begin
                gnt_nxt = '0;
                if (pick_any) begin
                    gnt_nxt     = pick;
                    gnt_idx_nxt = pick_idx;
                    cnt_nxt     = '0;
                    state_nxt   = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!req_held) begin
                    // Consumer released early; nothing moved this cycle.
                    gnt_nxt     = '0;
                    rr_last_nxt = gnt_idx_q;
                    state_nxt   = ST_IDLE;
                end else if (xfer) begin
                    cnt_nxt = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        gnt_nxt     = '0;
                        rr_last_nxt = gnt_idx_q;
                        state_nxt   = ST_IDLE;
                    end
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_arbiter
//   Directed bench for fifo_rd_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4).
//   A table of per-cycle records {reset, req, rdy, rd_empty, expected gnt,
//   rd_inc, busy} is applied one cycle per entry; a hand-written sequence
//   with a small FIFO occupancy model covers the 10-word burst-cap case.
// ---------------------------------------------------------------------------
module tb_fifo_rd_arbiter;

    logic rd_clk;
    logic rd_rst;

    fifo_rd_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    fifo_rd_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .BURST_LEN  (4)
    ) dut (
        .rd_clk (rd_clk),
        .rd_rst (rd_rst),
        .bus    (bus)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] rdy;
        logic       emp;
        logic [3:0] gnt;
        logic       inc;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input int n, input logic rst_n, input logic [3:0] req,
                       input logic [3:0] rdy, input logic emp, input logic [3:0] gnt,
                       input logic inc, input logic busy);
        vec_t v;
        v.rst_n = rst_n; v.req = req; v.rdy = rdy; v.emp = emp;
        v.gnt = gnt; v.inc = inc; v.busy = busy;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    initial begin
        logic [7:0] dval;
        int         words;
        int         pops;
        int         pops_at_bubble;

        n_checks = 0;
        n_fail   = 0;
        rd_rst       = 1'b0;
        bus.req      = 4'h0;
        bus.rdy      = 4'h0;
        bus.rd_empty = 1'b1;
        bus.rd_data  = 8'h00;

        // Reset held with all requests up, then released.
        add(2, 1'b0, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        add(1, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        // Round robin 0,1,2,3 with four words each and a bubble between.
        add(4, 1'b1, 4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1);
        add(1, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        add(4, 1'b1, 4'hF, 4'hF, 1'b0, 4'h2, 1'b1, 1'b1);
        add(1, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        add(4, 1'b1, 4'hF, 4'hF, 1'b0, 4'h4, 1'b1, 1'b1);
        add(1, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        add(4, 1'b1, 4'hF, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1);
        add(1, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        // Back to consumer 0, two words, then reset mid-burst.
        add(2, 1'b1, 4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1);
        add(1, 1'b0, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        add(1, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        add(1, 1'b1, 4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1);
        // Consumer 0 drops req: release with no pop.
        add(1, 1'b1, 4'hC, 4'hF, 1'b0, 4'h1, 1'b0, 1'b1);
        add(1, 1'b1, 4'hC, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        // Consumer 2 takes two words then drops req; consumer 3 follows.
        add(2, 1'b1, 4'hC, 4'hF, 1'b0, 4'h4, 1'b1, 1'b1);
        add(1, 1'b1, 4'h8, 4'hF, 1'b0, 4'h4, 1'b0, 1'b1);
        add(1, 1'b1, 4'h8, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        add(1, 1'b1, 4'h8, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1);
        add(1, 1'b1, 4'h2, 4'hF, 1'b0, 4'h8, 1'b0, 1'b1);
        add(1, 1'b1, 4'h2, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        // Consumer 1 stalls on rdy[1] and rd_empty.
        add(1, 1'b1, 4'h2, 4'hF, 1'b0, 4'h2, 1'b1, 1'b1);
        add(1, 1'b1, 4'h2, 4'hD, 1'b0, 4'h2, 1'b0, 1'b1);
        add(1, 1'b1, 4'h2, 4'hF, 1'b1, 4'h2, 1'b0, 1'b1);
        add(1, 1'b1, 4'h2, 4'hD, 1'b1, 4'h2, 1'b0, 1'b1);
        add(1, 1'b1, 4'h2, 4'h2, 1'b0, 4'h2, 1'b1, 1'b1);
        add(1, 1'b1, 4'h2, 4'hD, 1'b0, 4'h2, 1'b0, 1'b1);
        add(1, 1'b1, 4'h2, 4'h2, 1'b0, 4'h2, 1'b1, 1'b1);
        add(1, 1'b1, 4'h2, 4'hF, 1'b0, 4'h2, 1'b1, 1'b1);
        // Single requester is re-granted after the bubble.
        add(1, 1'b1, 4'h2, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        add(1, 1'b1, 4'h2, 4'hF, 1'b0, 4'h2, 1'b1, 1'b1);
        add(1, 1'b1, 4'h1, 4'hF, 1'b0, 4'h2, 1'b0, 1'b1);
        add(1, 1'b1, 4'h1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        // Consumer 0 alone: 4 + bubble + 4 + bubble + 2, then FIFO runs dry.
        add(4, 1'b1, 4'h1, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1);
        add(1, 1'b1, 4'h1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        add(4, 1'b1, 4'h1, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1);
        add(1, 1'b1, 4'h1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        add(2, 1'b1, 4'h1, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1);
        add(2, 1'b1, 4'h1, 4'hF, 1'b1, 4'h1, 1'b0, 1'b1);
        add(1, 1'b1, 4'h0, 4'hF, 1'b1, 4'h1, 1'b0, 1'b1);
        add(1, 1'b1, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        // Consumer 3 alone, index wraps 3 -> scan 0,1,2,3.
        add(1, 1'b1, 4'h8, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        add(1, 1'b1, 4'h8, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1);
        add(1, 1'b1, 4'h0, 4'hF, 1'b0, 4'h8, 1'b0, 1'b1);
        add(1, 1'b1, 4'h8, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
        add(1, 1'b1, 4'h8, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1);

        step();
        for (int i = 0; i < vecs.size(); i++) begin
            dval         = 8'((i * 37) ^ 8'h5A);
            rd_rst       = vecs[i].rst_n;
            bus.req      = vecs[i].req;
            bus.rdy      = vecs[i].rdy;
            bus.rd_empty = vecs[i].emp;
            bus.rd_data  = dval;
            #1;
            chk("gnt",       i, 32'(bus.gnt),       32'(vecs[i].gnt));
            chk("rd_inc",    i, 32'(bus.rd_inc),    32'(vecs[i].inc));
            chk("out_valid", i, 32'(bus.out_valid), 32'(vecs[i].gnt & {4{vecs[i].inc}}));
            chk("busy",      i, 32'(bus.busy),      32'(vecs[i].busy));
            chk("out_data",  i, 32'(bus.out_data),  32'(dval));
            step();
        end

        // Burst cap with a 10-word FIFO occupancy model for consumer 0.
        rd_rst       = 1'b0;
        bus.req      = 4'h0;
        bus.rdy      = 4'hF;
        bus.rd_empty = 1'b1;
        step();
        rd_rst  = 1'b1;
        bus.req = 4'h1;
        words   = 10;
        pops    = 0;
        pops_at_bubble = -1;
        for (int c = 0; c < 20; c++) begin
            bus.rd_empty = (words == 0);
            bus.rd_data  = 8'(words);
            #1;
            if (bus.rd_inc === 1'b1) begin
                pops++;
                words--;
            end
            if (c == 5) pops_at_bubble = pops;
            step();
        end
        #1;
        chk("cap_bubble_pops", 0, 32'(pops_at_bubble), 32'd4);
        chk("cap_total_pops",  0, 32'(pops),           32'd10);
        chk("cap_gnt_held",    0, 32'(bus.gnt),        32'h1);
        chk("cap_busy_held",   0, 32'(bus.busy),       32'h1);
        chk("cap_inc_stall",   0, 32'(bus.rd_inc),     32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
